// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared sizes, default thresholds and pointer type for the sync FIFO
package fifo_sync_pkg;

  localparam int AW_DEF        = 12;
  localparam int DW_DEF        = 8;
  localparam int DEPTH         = 2 ** AW_DEF;
  localparam int CW            = AW_DEF + 1;
  localparam int AEMPTY_TH_DEF = 4;
  localparam int AFULL_TH_DEF  = DEPTH - 4;

  // Pointer carries one extra wrap bit above the RAM address
  typedef logic [CW-1:0] ptr_t;

endpackage

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - maps next occupancy to the four status flag next-values
module fifo_sync_flags
  import fifo_sync_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF
) (
  input  logic [AW:0] count_next,
  output logic        empty_next,
  output logic        aempty_next,
  output logic        full_next,
  output logic        afull_next
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_TH);

  assign empty_next  = (count_next == '0);
  assign full_next   = (count_next == FULL_CNT);
  assign aempty_next = (count_next <= AE_CNT);
  assign afull_next  = (count_next >= AF_CNT);

endmodule

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO pointer/count/flag controller driving an external RAM
module fifo_sync_ctrl
  import fifo_sync_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF
) (
  input  logic          pos_rclk,
  input  logic          aresetn,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          aempty,
  output logic          full,
  output logic          afull,
  output logic          wr_ack,
  output logic          overflow,
  output logic          underflow,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count_next;
  logic        we_acc;
  logic        re_acc;
  logic        empty_next;
  logic        aempty_next;
  logic        full_next;
  logic        afull_next;

  // Flags are sampled before the update, so a write at full is dropped even with a read
  assign we_acc     = wr_en & ~full;
  assign re_acc     = rd_en & ~empty;
  assign count_next = count + {{AW{1'b0}}, we_acc} - {{AW{1'b0}}, re_acc};

  fifo_sync_flags #(
    .AW        (AW),
    .AEMPTY_TH (AEMPTY_TH),
    .AFULL_TH  (AFULL_TH)
  ) u_flags (
    .count_next  (count_next),
    .empty_next  (empty_next),
    .aempty_next (aempty_next),
    .full_next   (full_next),
    .afull_next  (afull_next)
  );

  always_ff @(posedge pos_rclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + {{AW{1'b0}}, we_acc};
      rptr      <= rptr + {{AW{1'b0}}, re_acc};
      count     <= count_next;
      empty     <= empty_next;
      aempty    <= aempty_next;
      full      <= full_next;
      afull     <= afull_next;
      wr_ack    <= we_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // RAM strobes are held off for the whole time reset is asserted
  assign mem_we    = we_acc & aresetn;
  assign mem_re    = re_acc & aresetn;
  assign mem_waddr = wptr[AW-1:0];
  assign mem_raddr = rptr[AW-1:0];
  assign mem_wdata = din;
  assign dout      = mem_rdata;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - self-checking bench: vector table, directed corners, random vs queue model
module tb_fifo_sync_ctrl;

  localparam int N   = 4096;
  localparam int AET = 4;
  localparam int AFT = 4092;

  logic        pos_rclk;
  logic        aresetn;
  logic        wr_en;
  logic [7:0]  din;
  logic        rd_en;
  logic [7:0]  dout;
  logic        empty, aempty, full, afull;
  logic        wr_ack, overflow, underflow;
  logic [12:0] count;
  logic [11:0] mem_waddr, mem_raddr;
  logic        mem_we, mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  fifo_sync_ctrl dut (
    .pos_rclk  (pos_rclk),
    .aresetn   (aresetn),
    .wr_en     (wr_en),
    .din       (din),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .aempty    (aempty),
    .full      (full),
    .afull     (afull),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .underflow (underflow),
    .count     (count),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial pos_rclk = 1'b0;
  always #5 pos_rclk = ~pos_rclk;

  // External registered RAM
  logic [7:0] ram [0:N-1];
  always @(posedge pos_rclk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int         wp = 0;
  int         rp = 0;
  logic       smp_mem_re;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       emp;
    logic       aemp;
    logic       uf;
    logic       mre;
    logic       dchk;
    logic [7:0] dexp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_empty"},     32'(empty),     32'd1);
    check({tag, "_aempty"},    32'(aempty),    32'd1);
    check({tag, "_full"},      32'(full),      32'd0);
    check({tag, "_afull"},     32'(afull),     32'd0);
    check({tag, "_wr_ack"},    32'(wr_ack),    32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_re"},    32'(mem_re),    32'd0);
  endtask

  // One clock of stimulus; model decides acceptance from occupancy before the edge
  task automatic drive(input logic wr, input logic rd, input logic [7:0] d);
    bit         wa, ra;
    int         sz;
    logic [7:0] ev;
    @(negedge pos_rclk);
    wr_en = wr; rd_en = rd; din = d;
    sz = q.size();
    wa = wr && (sz < N);
    ra = rd && (sz > 0);
    #1;
    smp_mem_re = mem_re;
    check("mem_we", 32'(mem_we), 32'(wa));
    check("mem_re", 32'(mem_re), 32'(ra));
    if (wa) begin
      check("mem_waddr", 32'(mem_waddr), 32'(wp));
      check("mem_wdata", 32'(mem_wdata), 32'(d));
    end
    if (ra) check("mem_raddr", 32'(mem_raddr), 32'(rp));
    @(posedge pos_rclk);
    #1;
    if (ra) begin
      ev = q.pop_front();
      rp = (rp + 1) % N;
      check("dout", 32'(dout), 32'(ev));
    end
    if (wa) begin
      q.push_back(d);
      wp = (wp + 1) % N;
    end
    sz = q.size();
    check("count",     32'(count),     32'(sz));
    check("empty",     32'(empty),     32'(sz == 0));
    check("full",      32'(full),      32'(sz == N));
    check("aempty",    32'(aempty),    32'(sz <= AET));
    check("afull",     32'(afull),     32'(sz >= AFT));
    check("wr_ack",    32'(wr_ack),    32'(wa));
    check("overflow",  32'(overflow),  32'(wr && !wa));
    check("underflow", 32'(underflow), 32'(rd && !ra));
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'hA2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'hA3, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    aresetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    repeat (3) @(posedge pos_rclk);
    #1;
    check_reset_outputs("rst");
    @(negedge pos_rclk);
    aresetn = 1'b1;

    // Basic write/read vectors
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].d);
      check($sformatf("tbl%0d_count", i),     32'(count),      32'(tbl[i].cnt));
      check($sformatf("tbl%0d_empty", i),     32'(empty),      32'(tbl[i].emp));
      check($sformatf("tbl%0d_aempty", i),    32'(aempty),     32'(tbl[i].aemp));
      check($sformatf("tbl%0d_underflow", i), 32'(underflow),  32'(tbl[i].uf));
      check($sformatf("tbl%0d_mem_re", i),    32'(smp_mem_re), 32'(tbl[i].mre));
      if (tbl[i].dchk) check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dexp));
    end

    // Fill to full, then one more write
    for (int i = 1; i <= N + 1; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      if (i == AFT - 1) check("afull_before_th", 32'(afull), 32'd0);
      if (i == AFT)     check("afull_at_th",     32'(afull), 32'd1);
      if (i == N - 1)   check("full_before",     32'(full),  32'd0);
      if (i == N)       check("full_at_depth",   32'(full),  32'd1);
    end
    check("ovf_count", 32'(count), 32'(N));
    check("ovf_flag",  32'(overflow), 32'd1);

    // Simultaneous read/write at full: write dropped
    drive(1'b1, 1'b1, 8'hEE);
    check("fullrw_count", 32'(count), 32'(N - 1));
    check("fullrw_full",  32'(full), 32'd0);
    check("fullrw_ovf",   32'(overflow), 32'd1);

    // Drain to 5, then long streaming with incrementing data
    while (q.size() > 5) drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10000; i++) drive(1'b1, 1'b1, 8'(i));
    check("stream_count", 32'(count), 32'd5);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Reset mid-stream at count 100
    while (q.size() < 100) drive(1'b1, 1'b0, 8'($urandom));
    while (q.size() > 100) drive(1'b0, 1'b1, 8'h00);
    check("pre_reset_count", 32'(count), 32'd100);
    @(negedge pos_rclk);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h33;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge pos_rclk);
    #1;
    check_reset_outputs("mid_rst_hold");
    q.delete(); wp = 0; rp = 0;
    @(negedge pos_rclk);
    aresetn = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge pos_rclk);
    wr_en = 1'b1; din = 8'h5A;
    #1;
    check("post_rst_waddr", 32'(mem_waddr), 32'd0);
    wr_en = 1'b0;
    drive(1'b1, 1'b0, 8'h5A);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
